// File: rtl/mem_rd_assembler.sv
// Load-data assembler: rotates/merges dcache lines or takes IO data, size-masks, strobes result.
// Optional sign fill of upper bytes when MEM_RD_SIGN_EXT_EN is defined.
module mem_rd_assembler #(
  parameter int LINE_BYTES = 16,
  parameter int OUT_BYTES  = 8,
  parameter int IO_W       = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_vld,
  output logic                            req_rdy,
  input  logic [$clog2(LINE_BYTES)-1:0]   req_offset,
  input  logic [$clog2(OUT_BYTES):0]      req_size,
  input  logic                            req_io,
  input  logic                            req_signed,
  input  logic                            flush,
  input  logic                            dc_hit,
  input  logic [LINE_BYTES*8-1:0]         dc_rd_data,
  output logic                            acc2,
  input  logic                            io_ack,
  input  logic [IO_W-1:0]                 io_rd_data,
  output logic                            rd_vld,
  output logic [OUT_BYTES*8-1:0]          rd_data
);

  localparam int OW = $clog2(LINE_BYTES);
  localparam int SW = $clog2(OUT_BYTES) + 1;
  localparam int DW = OUT_BYTES * 8;

  typedef enum logic [2:0] {
    S_IDLE, S_ACC1, S_ACC2, S_IOW, S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [OW-1:0]   r_off;
  logic [SW-1:0]   r_size;
  logic            r_io;
  logic            r_sgn;
  logic [DW-1:0]   r_mdr;
  logic [DW-1:0]   r_data;
  logic [SW-1:0]   w_size;
  logic [DW-1:0]   w_rot;
  logic [DW-1:0]   w_asm;
  logic [DW-1:0]   w_res;
  logic            w_split;
  logic            w_done;
  logic            w_fill;
  logic            w_take;

  assign w_take = (r_state == S_IDLE) && req_vld;

  // Out-of-range sizes mean a full-width load.
  assign w_size = (req_size == '0 || int'(req_size) > OUT_BYTES)
                ? SW'(OUT_BYTES) : req_size;

  assign w_split = (int'(r_off) + int'(r_size)) > LINE_BYTES;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_vld) w_next = req_io ? S_IOW : S_ACC1;
      S_ACC1: begin
        if (flush)       w_next = S_IDLE;
        else if (dc_hit) w_next = w_split ? S_ACC2 : S_RESP;
      end
      S_ACC2: begin
        if (flush)       w_next = S_IDLE;
        else if (dc_hit) w_next = S_RESP;
      end
      S_IOW: begin
        if (flush)       w_next = S_IDLE;
        else if (io_ack) w_next = S_RESP;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_rdy = (r_state == S_IDLE);
    acc2    = (r_state == S_ACC2);
    rd_vld  = (r_state == S_RESP);
  end

  assign w_done = !flush &&
                  ((r_state == S_ACC1 && dc_hit && !w_split) ||
                   (r_state == S_ACC2 && dc_hit) ||
                   (r_state == S_IOW  && io_ack));

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < OUT_BYTES; i++)
      w_rot[i*8 +: 8] =
        dc_rd_data[8*((i + int'(r_off)) % LINE_BYTES) +: 8];
  end

  // Second access: bytes still inside the first line come from the MDR.
  always_comb begin
    w_asm = '0;
    unique case (1'b1)
      (r_state == S_IOW):  w_asm[IO_W-1:0] = io_rd_data;
      (r_state == S_ACC2): begin
        for (int i = 0; i < OUT_BYTES; i++)
          w_asm[i*8 +: 8] = (i + int'(r_off) < LINE_BYTES)
                          ? r_mdr[i*8 +: 8] : w_rot[i*8 +: 8];
      end
      default:             w_asm = w_rot;
    endcase
  end

`ifdef MEM_RD_SIGN_EXT_EN
  assign w_fill = r_sgn && w_asm[8*int'(r_size)-1];
`else
  logic w_unused_sgn;
  assign w_unused_sgn = r_sgn;
  assign w_fill       = 1'b0;
`endif

  always_comb begin
    w_res = w_asm;
    for (int i = 0; i < OUT_BYTES; i++)
      if (i >= int'(r_size)) w_res[i*8 +: 8] = {8{w_fill}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_off  <= '0;
      r_size <= SW'(OUT_BYTES);
      r_io   <= 1'b0;
      r_sgn  <= 1'b0;
      r_mdr  <= '0;
      r_data <= '0;
    end else begin
      if (w_take) begin
        r_off  <= req_offset;
        r_size <= w_size;
        r_io   <= req_io;
        r_sgn  <= req_signed;
      end
      if (r_state == S_ACC1 && dc_hit && w_split && !flush)
        r_mdr <= w_rot;
      if (w_done)
        r_data <= w_res;
    end
  end

  assign rd_data = r_data;

endmodule
